// File: rtl/seq_shifter.sv
// seq_shifter: iterative one-bit-per-cycle shift/rotate unit.
// A request accepted in IDLE loads the working register and a step count.
// SHIFT applies one step per clock until the count runs out, and DONE
// raises a single-cycle completion pulse before the unit returns to IDLE.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_count;
  logic [2:0]       r_op;
  logic             r_illegal;
  logic             w_accept;
  logic             w_op_illegal;

  // Single one-bit step of the selected operation; illegal codes leave the value as is.
  function automatic logic [WIDTH-1:0] f_step(input logic [2:0] step_op,
                                              input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] s;
    case (step_op)
      OP_SLL:  s = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  s = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  s = {v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  s = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  s = {v[0], v[WIDTH-1:1]};
      default: s = v;
    endcase
    return s;
  endfunction

  // Codes above ROR have no defined operation.
  function automatic logic f_is_illegal(input logic [2:0] chk_op);
    logic bad;
    case (chk_op)
      OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: bad = 1'b0;
      default:                                bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign w_accept     = (r_state == ST_IDLE) && start;
  assign w_op_illegal = f_is_illegal(op);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_op_illegal || (amount == {AMT_W{1'b0}})) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_count == AMT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the state register; err only qualifies the DONE pulse.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    case (r_state)
      ST_IDLE:  busy = 1'b0;
      ST_SHIFT: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        err  = r_illegal;
      end
      default: busy = 1'b0;
    endcase
  end

  // Working register, step count and latched op: loaded on accept, stepped in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work    <= {WIDTH{1'b0}};
      r_count   <= {AMT_W{1'b0}};
      r_op      <= 3'b000;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_work    <= w_op_illegal ? {WIDTH{1'b0}} : operand;
      r_count   <= amount;
      r_op      <= op;
      r_illegal <= w_op_illegal;
    end else if (r_state == ST_SHIFT) begin
      r_work  <= f_step(r_op, r_work);
      r_count <= r_count - AMT_W'(1);
    end else begin
      r_work  <= r_work;
      r_count <= r_count;
    end
  end

  assign result = r_work;

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed-vector bench for seq_shifter with hand-computed expectations.
module tb_seq_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand;
  logic [4:0]  amount;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec;
  int n_miss;

  seq_shifter #(.WIDTH(32), .AMT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .operand (operand),
    .amount  (amount),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in cycle T+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] v, input logic [4:0] a);
    start   = 1'b1;
    op      = o;
    operand = v;
    amount  = a;
    tick();
    start   = 1'b0;
  endtask

  // Wait up to a bound for done; lat = cycles waited beyond T+1.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: got no done expected done within 100 cycles", tag);
    end
  endtask

  // Full transaction: latency, result, err, busy at T+1, one-cycle done, busy low after.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] v,
                        input logic [4:0] a, input logic [31:0] exp_r,
                        input logic exp_e, input int exp_lat);
    int lat;
    issue(o, v, a);
    chk({tag, "_busy_t1"}, {31'd0, busy}, 32'd1);
    wait_done(tag, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_e});
    tick();
    chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hold"}, result, exp_r);
  endtask

  initial begin
    int lat;
    n_vec   = 0;
    n_miss  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 3'b000;
    operand = 32'd0;
    amount  = 5'd0;
    tick();
    tick();
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("sll4",    3'b000, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 4);
    run_op("sra31",   3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 31);
    run_op("srl31",   3'b001, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 31);
    run_op("ror1",    3'b100, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 1);
    run_op("rol4",    3'b011, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0, 4);
    run_op("ror8",    3'b100, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0, 8);
    run_op("sra_pos", 3'b010, 32'h4000_0000, 5'd3,  32'h0800_0000, 1'b0, 3);
    run_op("sll31",   3'b000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0, 31);
    run_op("amt0",    3'b000, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 0);
    run_op("ill110",  3'b110, 32'hDEAD_BEEF, 5'd7,  32'h0000_0000, 1'b1, 0);
    run_op("ill101",  3'b101, 32'hCAFE_F00D, 5'd0,  32'h0000_0000, 1'b1, 0);
    run_op("ill111",  3'b111, 32'h1111_1111, 5'd31, 32'h0000_0000, 1'b1, 0);

    // Start pulsed while busy must be ignored.
    issue(3'b001, 32'hF000_0000, 5'd8);
    tick();
    tick();
    start   = 1'b1;
    operand = 32'h1234_5678;
    op      = 3'b000;
    amount  = 5'd1;
    tick();
    start   = 1'b0;
    wait_done("busy_start", lat);
    chk("busy_start_lat", 32'(lat + 3), 32'd8);
    chk("busy_start_res", result, 32'h00F0_0000);
    tick();
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // Start in the done cycle is ignored; accepted only when re-asserted in IDLE.
    issue(3'b000, 32'h0000_0001, 5'd2);
    wait_done("done_start", lat);
    start   = 1'b1;
    op      = 3'b000;
    operand = 32'h0000_0005;
    amount  = 5'd1;
    tick();
    chk("done_start_ign_busy", {31'd0, busy}, 32'd0);
    chk("done_start_ign_res", result, 32'h0000_0004);
    tick();
    start = 1'b0;
    chk("done_start_acc_busy", {31'd0, busy}, 32'd1);
    wait_done("done_start2", lat);
    chk("done_start_acc_lat", 32'(lat), 32'd1);
    chk("done_start_acc_res", result, 32'h0000_000A);
    tick();

    // Reset mid-operation aborts without a done pulse.
    issue(3'b000, 32'h0000_0001, 5'd20);
    for (int i = 0; i < 9; i++) tick();
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res", result, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) lat++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) lat++;
    end
    chk("mid_rst_no_done", 32'(lat), 32'd0);
    run_op("post_rst", 3'b100, 32'h0000_00F0, 5'd4, 32'h0000_000F, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
